// File: rtl/dna_ip_ctrl.sv
// dna_ip_ctrl: control/status register bank and run sequencer for the DNA compute core.
// Define DNA_CTRL_IRQ_EN to build the registered level interrupt output o_irq.
module dna_ip_ctrl #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int LEN_W = 16,
  parameter int TMO_W = 24,
  parameter logic [TMO_W-1:0] TMO_DEFAULT = 24'hFFFFFF
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [3:0]            i_wen,
  input  logic [ADDR_WIDTH-1:0] i_addr_w,
  input  logic [DATA_WIDTH-1:0] i_data_w,
  input  logic [ADDR_WIDTH-1:0] i_addr_r,
  output logic [DATA_WIDTH-1:0] o_data_r,
  output logic                  o_core_start,
  output logic                  o_core_abort,
  output logic [LEN_W-1:0]      o_core_len,
  output logic                  o_core_mode,
  input  logic                  i_core_done,
  input  logic                  i_core_error,
  input  logic [DATA_WIDTH-1:0] i_core_result
`ifdef DNA_CTRL_IRQ_EN
  ,
  output logic                  o_irq
`endif
);

  // state    | meaning
  // S_IDLE   | waiting for a START write
  // S_LAUNCH | start pulse to core, watchdog cleared
  // S_RUN    | core running, watchdog counting
  typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_RUN} state_t;

  state_t state_q, state_d;

  logic                  wr;
  logic [2:0]            wsel, rsel;
  logic [DATA_WIDTH-1:0] byte_mask;
  logic                  wr_ctrl, wr_stat, wr_len, wr_tmo;
  logic                  start_wr, abort_wr, busy;
  logic [2:0]            w1c;

  logic [LEN_W-1:0]      len_q;
  logic [TMO_W-1:0]      tmo_limit_q, wdog_q;
  logic [DATA_WIDTH-1:0] result_q;
  logic                  done_q, err_q, tmo_q, mode_q, abort_q;
  logic                  irq_en_rd;

  logic set_done, set_err, set_tmo, abort_d;

  assign wr        = |i_wen;
  assign wsel      = i_addr_w[4:2];
  assign rsel      = i_addr_r[4:2];
  assign byte_mask = {{8{i_wen[3]}}, {8{i_wen[2]}}, {8{i_wen[1]}}, {8{i_wen[0]}}};
  assign wr_ctrl   = wr && (wsel == 3'd0);
  assign wr_stat   = wr && (wsel == 3'd1);
  assign wr_len    = wr && (wsel == 3'd2);
  assign wr_tmo    = wr && (wsel == 3'd4);
  assign start_wr  = wr_ctrl && i_wen[0] && i_data_w[0];
  assign abort_wr  = wr_ctrl && i_wen[0] && i_data_w[1];
  assign w1c       = (wr_stat && i_wen[0]) ? i_data_w[3:1] : 3'b000;
  assign busy      = (state_q != S_IDLE);

  always_comb begin
    state_d  = state_q;
    set_done = 1'b0;
    set_err  = 1'b0;
    set_tmo  = 1'b0;
    abort_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_wr) begin
          if (len_q != '0) state_d = S_LAUNCH;
          else             set_err = 1'b1;
        end
      end
      S_LAUNCH: state_d = S_RUN;
      S_RUN: begin
        if (i_core_done) begin
          set_done = 1'b1;
          set_err  = i_core_error;
          state_d  = S_IDLE;
        end else if (abort_wr) begin
          abort_d = 1'b1;
          set_err = 1'b1;
          state_d = S_IDLE;
        end else if ((tmo_limit_q != '0) && (wdog_q == tmo_limit_q)) begin
          abort_d = 1'b1;
          set_tmo = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      abort_q <= 1'b0;
      wdog_q  <= '0;
    end else begin
      state_q <= state_d;
      abort_q <= abort_d;
      if (state_q == S_LAUNCH)
        wdog_q <= '0;
      else if ((state_q == S_RUN) && (wdog_q != {TMO_W{1'b1}}))
        wdog_q <= wdog_q + TMO_W'(1);
    end
  end

  // Hardware set takes priority over a coincident W1C clear.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      tmo_q       <= 1'b0;
      result_q    <= '0;
      len_q       <= '0;
      tmo_limit_q <= TMO_DEFAULT;
      mode_q      <= 1'b0;
    end else begin
      done_q <= set_done | (done_q & ~w1c[0]);
      err_q  <= set_err  | (err_q  & ~w1c[1]);
      tmo_q  <= set_tmo  | (tmo_q  & ~w1c[2]);
      if (set_done)
        result_q <= i_core_result;
      if (wr_len && !busy)
        len_q <= (len_q & ~byte_mask[LEN_W-1:0]) | (i_data_w[LEN_W-1:0] & byte_mask[LEN_W-1:0]);
      if (wr_tmo)
        tmo_limit_q <= (tmo_limit_q & ~byte_mask[TMO_W-1:0]) |
                       (i_data_w[TMO_W-1:0] & byte_mask[TMO_W-1:0]);
      // MODE is frozen while a job runs so the core sees a stable value.
      if (wr_ctrl && i_wen[0] && !busy)
        mode_q <= i_data_w[3];
    end
  end

`ifdef DNA_CTRL_IRQ_EN
  logic irq_en_q, irq_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      irq_en_q <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      if (wr_ctrl && i_wen[0])
        irq_en_q <= i_data_w[2];
      irq_q <= irq_en_q & (done_q | err_q | tmo_q);
    end
  end

  assign irq_en_rd = irq_en_q;
  assign o_irq     = irq_q;
`else
  assign irq_en_rd = 1'b0;
`endif

  always_comb begin
    o_data_r = '0;
    case (rsel)
      3'd0:    o_data_r[3:2] = {mode_q, irq_en_rd};
      3'd1:    o_data_r[3:0] = {tmo_q, err_q, done_q, busy};
      3'd2:    o_data_r[LEN_W-1:0] = len_q;
      3'd3:    o_data_r = result_q;
      3'd4:    o_data_r[TMO_W-1:0] = tmo_limit_q;
      default: o_data_r = '0;
    endcase
  end

  assign o_core_start = (state_q == S_LAUNCH);
  assign o_core_abort = abort_q;
  assign o_core_len   = len_q;
  assign o_core_mode  = mode_q;

  // Address bits outside addr[4:2] alias by design; upper data bits have no home.
  logic unused_bits;
  assign unused_bits = ^{i_addr_w, i_addr_r, i_data_w, i_wen};

endmodule

// File: tb/tb_dna_ip_ctrl.sv
// Self-checking bench for dna_ip_ctrl: directed cases plus randomized traffic
// compared every cycle against a behavioural register/sequencer model.
module tb_dna_ip_ctrl;

  logic        clk = 1'b0;
  logic        resetn;
  logic [3:0]  wen;
  logic [31:0] addr_w, data_w, addr_r, data_r;
  logic        core_start, core_abort, core_mode;
  logic [15:0] core_len;
  logic        core_done, core_error;
  logic [31:0] core_result;
`ifdef DNA_CTRL_IRQ_EN
  logic        irq;
`endif

  dna_ip_ctrl dut (
    .clk          (clk),
    .resetn       (resetn),
    .i_wen        (wen),
    .i_addr_w     (addr_w),
    .i_data_w     (data_w),
    .i_addr_r     (addr_r),
    .o_data_r     (data_r),
    .o_core_start (core_start),
    .o_core_abort (core_abort),
    .o_core_len   (core_len),
    .o_core_mode  (core_mode),
    .i_core_done  (core_done),
    .i_core_error (core_error),
    .i_core_result(core_result)
`ifdef DNA_CTRL_IRQ_EN
    ,
    .o_irq        (irq)
`endif
  );

  always #10 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  bit          m_launch, m_run, m_abort, m_done, m_err, m_tmo, m_mode, m_irq_en, m_irq;
  logic [15:0] m_len;
  logic [31:0] m_result;
  logic [23:0] m_tmo_lim;
  int unsigned m_wd;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_launch = 0; m_run = 0; m_abort = 0; m_done = 0; m_err = 0; m_tmo = 0;
    m_mode = 0; m_irq_en = 0; m_irq = 0;
    m_len = '0; m_result = '0; m_tmo_lim = 24'hFFFFFF; m_wd = 0;
  endtask

  function automatic logic [31:0] m_read(logic [31:0] a);
    logic [31:0] v;
    bit ie;
    v = '0;
`ifdef DNA_CTRL_IRQ_EN
    ie = m_irq_en;
`else
    ie = 1'b0;
`endif
    case (a[4:2])
      3'd0: v = {28'd0, m_mode, ie, 2'b00};
      3'd1: v = {28'd0, m_tmo, m_err, m_done, (m_launch || m_run)};
      3'd2: v = {16'd0, m_len};
      3'd3: v = m_result;
      3'd4: v = {8'd0, m_tmo_lim};
      default: v = '0;
    endcase
    return v;
  endfunction

  // Advance the model across one rising edge using the inputs currently driven.
  task automatic model_step();
    logic [31:0] mask;
    logic [2:0]  clr;
    int          sel;
    bit wr, busy, start_w, abort_w, s_done, s_err, s_tmo, n_launch, n_run, n_abort, n_irq;
    for (int b = 0; b < 4; b++) mask[b*8 +: 8] = {8{wen[b]}};
    wr      = |wen;
    sel     = int'(addr_w[4:2]);
    busy    = m_launch || m_run;
    start_w = wr && sel == 0 && wen[0] && data_w[0];
    abort_w = wr && sel == 0 && wen[0] && data_w[1];
    s_done = 0; s_err = 0; s_tmo = 0; n_launch = 0; n_abort = 0; n_run = m_run;
    n_irq = m_irq_en && (m_done || m_err || m_tmo);
    if (m_launch) begin
      n_run = 1;
      m_wd  = 0;
    end else if (m_run) begin
      if (core_done) begin
        m_result = core_result; s_done = 1; s_err = core_error; n_run = 0;
      end else if (abort_w) begin
        n_abort = 1; s_err = 1; n_run = 0;
      end else if (m_tmo_lim != 0 && m_wd == m_tmo_lim) begin
        n_abort = 1; s_tmo = 1; n_run = 0;
      end else if (m_wd < 32'hFFFFFF) begin
        m_wd++;
      end
    end else if (start_w) begin
      if (m_len != 0) n_launch = 1;
      else            s_err = 1;
    end
    clr    = (wr && sel == 1 && wen[0]) ? data_w[3:1] : 3'b000;
    m_done = s_done || (m_done && !clr[0]);
    m_err  = s_err  || (m_err  && !clr[1]);
    m_tmo  = s_tmo  || (m_tmo  && !clr[2]);
    if (wr && sel == 2 && !busy) m_len = (m_len & ~mask[15:0]) | (data_w[15:0] & mask[15:0]);
    if (wr && sel == 4) m_tmo_lim = (m_tmo_lim & ~mask[23:0]) | (data_w[23:0] & mask[23:0]);
    if (wr && sel == 0 && wen[0]) begin
      if (!busy) m_mode = data_w[3];
      m_irq_en = data_w[2];
    end
    m_launch = n_launch; m_run = n_run; m_abort = n_abort; m_irq = n_irq;
  endtask

  task automatic compare_all();
    chk("core_start", {31'd0, core_start}, {31'd0, m_launch});
    chk("core_abort", {31'd0, core_abort}, {31'd0, m_abort});
    chk("core_len",   {16'd0, core_len},   {16'd0, m_len});
    chk("core_mode",  {31'd0, core_mode},  {31'd0, m_mode});
    chk("data_r",     data_r,              m_read(addr_r));
`ifdef DNA_CTRL_IRQ_EN
    chk("irq",        {31'd0, irq},        {31'd0, m_irq});
`endif
  endtask

  task automatic tick();
    #1;
    compare_all();
    model_step();
    @(negedge clk);
  endtask

  task automatic wr_reg(logic [31:0] a, logic [31:0] d, logic [3:0] w);
    addr_w = a; data_w = d; wen = w;
    tick();
    wen = 4'h0;
  endtask

  task automatic idle(int n);
    repeat (n) tick();
  endtask

  task automatic expect_reg(string name, logic [31:0] a, logic [31:0] exp);
    addr_r = a;
    #1;
    chk(name, data_r, exp);
  endtask

  initial begin
    int k;
    resetn = 1'b0; wen = 4'h0; addr_w = '0; data_w = '0; addr_r = '0;
    core_done = 1'b0; core_error = 1'b0; core_result = '0;
    model_reset();
    @(negedge clk);
    #1;
    chk("rst_start", {31'd0, core_start}, 32'd0);
    chk("rst_abort", {31'd0, core_abort}, 32'd0);
    chk("rst_len",   {16'd0, core_len},   32'd0);
    expect_reg("rst_stat", 32'h4, 32'h0);
    expect_reg("rst_tmo",  32'h10, 32'h00FFFFFF);
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);

    // Normal job: start pulse one cycle after START write
    wr_reg(32'h8, 32'h0010, 4'hF);
    wr_reg(32'h0, 32'h1, 4'h1);
    chk("start_pulse_n1", {31'd0, core_start}, 32'd1);
    expect_reg("busy_after_start", 32'h4, 32'h1);
    idle(19);
    core_done = 1'b1; core_result = 32'hCAFE0001; core_error = 1'b0;
    tick();
    core_done = 1'b0;
    expect_reg("result", 32'hC, 32'hCAFE0001);
    expect_reg("stat_done", 32'h4, 32'h2);
    expect_reg("len_alias", 32'hFFFF_FF2B, 32'h0010);

    // START with LEN==0
    wr_reg(32'h4, 32'hE, 4'h1);
    wr_reg(32'h8, 32'h0, 4'hF);
    wr_reg(32'h0, 32'h1, 4'h1);
    chk("no_start_len0", {31'd0, core_start}, 32'd0);
    expect_reg("stat_err", 32'h4, 32'h4);
    wr_reg(32'h4, 32'h4, 4'h1);
    expect_reg("stat_w1c_err", 32'h4, 32'h0);

    // Watchdog timeout with limit 8
    wr_reg(32'h10, 32'h8, 4'hF);
    wr_reg(32'h8, 32'h5, 4'hF);
    wr_reg(32'h0, 32'h1, 4'h1);
    k = 0;
    while (!core_abort && k < 50) begin
      tick();
      k++;
    end
    chk("tmo_latency", k, 32'd10);
    expect_reg("stat_tmo", 32'h4, 32'h8);
    wr_reg(32'h4, 32'hE, 4'h1);
    wr_reg(32'h10, 32'h0, 4'hF);

    // Done and abort write in the same cycle; LEN write during RUN ignored
    wr_reg(32'h0, 32'h9, 4'h1);
    chk("mode_out", {31'd0, core_mode}, 32'd1);
    idle(3);
    wr_reg(32'h8, 32'h77, 4'hF);
    expect_reg("len_locked", 32'h8, 32'h5);
    core_done = 1'b1; core_result = 32'h1234; core_error = 1'b0;
    addr_w = 32'h0; data_w = 32'h2; wen = 4'h1;
    tick();
    wen = 4'h0; core_done = 1'b0;
    chk("no_abort_on_done", {31'd0, core_abort}, 32'd0);
    expect_reg("stat_done_wins", 32'h4, 32'h2);

    // Byte strobes on LEN; W1C of DONE coincident with a new done
    wr_reg(32'h8, 32'h0, 4'hF);
    wr_reg(32'h8, 32'hAB00, 4'b0010);
    expect_reg("len_byte1", 32'h8, 32'hAB00);
    wr_reg(32'h0, 32'h1, 4'h1);
    idle(3);
    core_done = 1'b1; core_result = 32'h55AA; core_error = 1'b1;
    addr_w = 32'h4; data_w = 32'h2; wen = 4'h1;
    tick();
    wen = 4'h0; core_done = 1'b0; core_error = 1'b0;
    expect_reg("stat_set_wins", 32'h4, 32'h6);
    wr_reg(32'h4, 32'h6, 4'h1);
    expect_reg("stat_cleared", 32'h4, 32'h0);

`ifdef DNA_CTRL_IRQ_EN
    wr_reg(32'h0, 32'h5, 4'h1);
    idle(2);
    core_done = 1'b1; core_result = 32'h1;
    tick();
    core_done = 1'b0;
    chk("irq_lag0", {31'd0, irq}, 32'd0);
    tick();
    chk("irq_set", {31'd0, irq}, 32'd1);
    wr_reg(32'h4, 32'h2, 4'h1);
    tick();
    chk("irq_clr", {31'd0, irq}, 32'd0);
`endif

    // Reset in the middle of a run: no abort pulse, everything cleared
    wr_reg(32'h8, 32'h3, 4'hF);
    wr_reg(32'h0, 32'h1, 4'h1);
    idle(2);
    #3 resetn = 1'b0;
    #1;
    chk("rst_mid_abort", {31'd0, core_abort}, 32'd0);
    expect_reg("rst_mid_stat", 32'h4, 32'h0);
    model_reset();
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);

    // Randomized traffic
    for (int c = 0; c < 4000; c++) begin
      int sel;
      logic [31:0] r;
      if ($urandom_range(0, 3) == 0) begin
        sel = int'($urandom_range(0, 7));
        r = $urandom();
        addr_w = (r & ~32'h1C) | (32'(sel) << 2);
        wen = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'hF;
        case (sel)
          0: data_w = $urandom_range(0, 15);
          1: data_w = $urandom_range(0, 15);
          2: data_w = ($urandom_range(0, 4) == 0) ? 32'h0 : $urandom_range(1, 40);
          4: data_w = $urandom_range(0, 30);
          default: data_w = $urandom();
        endcase
      end else begin
        wen = 4'h0;
      end
      core_done   = ($urandom_range(0, 11) == 0);
      core_error  = $urandom_range(0, 1) == 1;
      core_result = $urandom();
      addr_r      = (32'($urandom()) & ~32'h1C) | (32'($urandom_range(0, 7)) << 2);
      tick();
    end
    wen = 4'h0; core_done = 1'b0;
    idle(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
